// File: rtl/cpu_pkg.sv
// Shared CPU types: 32-bit machine word and the PC sequencer state encoding.
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/branch_cond.sv
// Resolves BEQ/BNE against the ALU zero flag; purely combinational.
module branch_cond (
  input  logic i_branch,
  input  logic i_branch_ne,
  input  logic i_zero,
  output logic o_cond
);

  assign o_cond = (i_branch & i_zero) | (i_branch_ne & ~i_zero);

endmodule

// File: rtl/pc_control.sv
// Program counter sequencer: BOOT hold, RUN next-PC select, sticky HALT.
// pcOut/takenCount/halted are registered; pcPlus4 and branchTaken are combinational.
module pc_control
  import cpu_pkg::*;
#(
  parameter word_t RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inpBranch,
  input  logic        inpBranchNe,
  input  logic        inpZero,
  input  logic        inpJump,
  input  logic [31:0] inpImm,
  input  logic [25:0] inpJumpAddr,
  input  logic        inpStall,
  input  logic        inpHalt,
  output logic [31:0] pcOut,
  output logic [31:0] pcPlus4,
  output logic        branchTaken,
  output logic [15:0] takenCount,
  output logic        halted
);

  pc_state_t   r_state;
  word_t       r_pc;
  logic [15:0] r_taken_cnt;
  logic        r_halted;

  logic  w_cond;
  logic  w_taken;
  word_t w_pc_plus4;
  word_t w_br_target;
  word_t w_jump_target;

  branch_cond u_branch_cond (
    .i_branch    (inpBranch),
    .i_branch_ne (inpBranchNe),
    .i_zero      (inpZero),
    .o_cond      (w_cond)
  );

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_br_target   = w_pc_plus4 + (inpImm << 2);
  assign w_jump_target = {w_pc_plus4[31:28], inpJumpAddr, 2'b00};

  // Reset is folded in so a branch presented alongside reset never reports taken.
  assign w_taken = (r_state == ST_RUN) & ~reset & ~inpHalt & ~inpStall & ~inpJump & w_cond;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_VECTOR;
      r_taken_cnt <= 16'd0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (inpHalt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (inpStall) begin
            r_pc <= r_pc;
          end else if (inpJump) begin
            r_pc <= w_jump_target;
          end else if (w_taken) begin
            r_pc <= w_br_target;
            if (r_taken_cnt != 16'hFFFF) begin
              r_taken_cnt <= r_taken_cnt + 16'd1;
            end
          end else begin
            r_pc <= w_pc_plus4;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state  <= ST_BOOT;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign pcOut       = r_pc;
  assign pcPlus4     = w_pc_plus4;
  assign branchTaken = w_taken;
  assign takenCount  = r_taken_cnt;
  assign halted      = r_halted;

endmodule

// File: tb/tb_pc_control.sv
// Bench for pc_control: directed scenarios plus random traffic against a behavioural PC model.
module tb_pc_control;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inpBranch = 1'b0;
  logic        inpBranchNe = 1'b0;
  logic        inpZero = 1'b0;
  logic        inpJump = 1'b0;
  logic [31:0] inpImm = 32'd0;
  logic [25:0] inpJumpAddr = 26'd0;
  logic        inpStall = 1'b0;
  logic        inpHalt = 1'b0;
  logic [31:0] pcOut;
  logic [31:0] pcPlus4;
  logic        branchTaken;
  logic [15:0] takenCount;
  logic        halted;

  int          errs = 0;
  int          checks = 0;
  logic [31:0] m_pc;
  int          m_cnt;
  int          m_mode;

  pc_control #(.RESET_VECTOR(RV)) dut (
    .clk         (clk),
    .reset       (reset),
    .inpBranch   (inpBranch),
    .inpBranchNe (inpBranchNe),
    .inpZero     (inpZero),
    .inpJump     (inpJump),
    .inpImm      (inpImm),
    .inpJumpAddr (inpJumpAddr),
    .inpStall    (inpStall),
    .inpHalt     (inpHalt),
    .pcOut       (pcOut),
    .pcPlus4     (pcPlus4),
    .branchTaken (branchTaken),
    .takenCount  (takenCount),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic br, input logic bne, input logic z, input logic j,
                       input logic [31:0] imm, input logic [25:0] ja,
                       input logic st, input logic h, input logic rst);
    inpBranch = br; inpBranchNe = bne; inpZero = z; inpJump = j;
    inpImm = imm; inpJumpAddr = ja; inpStall = st; inpHalt = h; reset = rst;
  endtask

  // One clock: check combinational outputs, clock, advance the model, check registered outputs.
  task automatic cycle();
    logic        cond;
    logic        e_bt;
    logic [31:0] e_p4;
    cond = (inpBranch && inpZero) || (inpBranchNe && !inpZero);
    e_p4 = m_pc + 32'd4;
    e_bt = (m_mode == M_RUN) && !reset && !inpHalt && !inpStall && !inpJump && cond;
    #1;
    chk_eq("pcPlus4", pcPlus4, e_p4);
    chk_eq("branchTaken", {31'd0, branchTaken}, {31'd0, e_bt});
    @(posedge clk);
    if (reset) begin
      m_pc = RV; m_cnt = 0; m_mode = M_BOOT;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (inpHalt) m_mode = M_HALT;
      else if (inpStall) m_pc = m_pc;
      else if (inpJump) m_pc = {e_p4[31:28], inpJumpAddr, 2'b00};
      else if (cond) begin
        m_pc = e_p4 + inpImm * 32'd4;
        if (m_cnt < 65535) m_cnt++;
      end else m_pc = e_p4;
    end
    #1;
    chk_eq("pcOut", pcOut, m_pc);
    chk_eq("takenCount", {16'd0, takenCount}, m_cnt);
    chk_eq("halted", {31'd0, halted}, {31'd0, m_mode == M_HALT});
    @(negedge clk);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 32'd0, 26'd0, 0, 0, 0);
    cycle();
  endtask

  initial begin
    m_pc = RV; m_cnt = 0; m_mode = M_BOOT;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_pc", pcOut, 32'h0);
    chk_eq("rst_cnt", {16'd0, takenCount}, 32'h0);
    chk_eq("rst_halted", {31'd0, halted}, 32'h0);
    drive(1, 0, 1, 0, 32'd4, 26'd0, 0, 0, 1);
    cycle();

    // Release: BOOT holds even with a true BEQ, then sequential fetch.
    drive(1, 0, 1, 0, 32'd4, 26'd0, 0, 0, 0);
    cycle();
    chk_eq("boot_pc", pcOut, 32'h0);
    nop(); chk_eq("seq_4", pcOut, 32'h4);
    nop(); chk_eq("seq_8", pcOut, 32'h8);
    nop(); chk_eq("seq_12", pcOut, 32'hC);
    chk_eq("seq_cnt", {16'd0, takenCount}, 32'h0);
    repeat (13) nop();
    chk_eq("at_40", pcOut, 32'h40);

    drive(1, 0, 1, 0, 32'hFFFF_FFFE, 26'd0, 0, 0, 0);
    #1 chk_eq("beq_bt", {31'd0, branchTaken}, 32'h1);
    cycle();
    chk_eq("beq_pc", pcOut, 32'h3C);
    chk_eq("beq_cnt", {16'd0, takenCount}, 32'h1);
    nop();
    drive(0, 1, 1, 0, 32'd8, 26'd0, 0, 0, 0);
    #1 chk_eq("bne_bt", {31'd0, branchTaken}, 32'h0);
    cycle();
    chk_eq("bne_pc", pcOut, 32'h44);
    drive(1, 0, 1, 1, 32'd8, 26'h100, 0, 0, 0);
    #1 chk_eq("jmp_bt", {31'd0, branchTaken}, 32'h0);
    cycle();
    chk_eq("jmp_pc", pcOut, 32'h400);

    repeat (3) begin
      drive(1, 0, 1, 0, 32'd8, 26'd0, 1, 0, 0);
      cycle();
    end
    chk_eq("stall_pc", pcOut, 32'h400);
    chk_eq("stall_cnt", {16'd0, takenCount}, 32'h1);
    drive(0, 0, 0, 0, 32'd0, 26'd0, 0, 1, 0);
    cycle();
    chk_eq("halt_flag", {31'd0, halted}, 32'h1);
    repeat (4) begin
      drive(1, 0, 1, $urandom_range(0, 1), $urandom, 26'($urandom), 0, $urandom_range(0, 1), 0);
      cycle();
    end
    chk_eq("halt_pc", pcOut, 32'h400);
    chk_eq("halt_cnt", {16'd0, takenCount}, 32'h1);
    drive(0, 0, 0, 0, 32'd0, 26'd0, 0, 0, 1);
    cycle();
    chk_eq("halt_rst_pc", pcOut, RV);
    chk_eq("halt_rst_flag", {31'd0, halted}, 32'h0);

    // Random traffic, including resets from RUN and HALT.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), $urandom, 26'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0),
            (m_mode == M_HALT) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0));
      cycle();
    end

    // PC wrap at the top of the address space.
    drive(0, 0, 0, 0, 32'd0, 26'd0, 0, 0, 1); cycle();
    nop();
    drive(1, 0, 1, 0, 32'h3FFF_FFFE, 26'd0, 0, 0, 0); cycle();
    chk_eq("wrap_pc", pcOut, 32'hFFFF_FFFC);
    #1 chk_eq("wrap_p4", pcPlus4, 32'h0);
    nop();
    chk_eq("wrap_next", pcOut, 32'h0);

    // Saturation: branch-to-self 65540 times.
    drive(0, 0, 0, 0, 32'd0, 26'd0, 0, 0, 1); cycle();
    nop();
    drive(1, 0, 1, 0, 32'hFFFF_FFFF, 26'd0, 0, 0, 0);
    repeat (65540) cycle();
    chk_eq("sat_cnt", {16'd0, takenCount}, 32'h0000_FFFF);
    chk_eq("sat_pc", pcOut, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
